// File: rtl/flop_mismatch_log.sv
// Failure logger for compare benches: skips a warm-up window, timestamps failing cycles,
// queues {timestamp, ok vector} in a FIFO and keeps sticky failure summaries.
module flop_mismatch_log #(
  parameter int NCHK   = 22,
  parameter int DEPTH  = 8,
  parameter int TSW    = 32,
  parameter int WARMUP = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            stop,
  input  logic [NCHK-1:0] ok,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [TSW-1:0]  rd_time,
  output logic [NCHK-1:0] rd_okvec,
  output logic            fail_any,
  output logic [TSW-1:0]  fail_count,
  output logic [TSW-1:0]  first_time,
  output logic            overflow,
  output logic            busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  typedef enum logic [1:0] {IDLE, WARM, CHECK} state_t;

  state_t          state, state_nxt;
  logic [WW-1:0]   warm_cnt;
  logic [TSW-1:0]  tstamp;
  logic [AW:0]     wr_ptr, rd_ptr;
  logic [TSW-1:0]  mem_time [DEPTH];
  logic [NCHK-1:0] mem_vec  [DEPTH];
  logic [NCHK-1:0] ok_clean;
  logic            start_edge, fail, empty, full, push, pop;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = WARM;
      WARM: begin
        if (stop)               state_nxt = IDLE;
        else if (warm_cnt == '0) state_nxt = CHECK;
      end
      CHECK:   if (stop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Only a clean 1 passes; X/Z are treated as failing and stored as 0.
  always_comb begin
    ok_clean = '0;
    for (int i = 0; i < NCHK; i++) ok_clean[i] = (ok[i] === 1'b1);
  end

  assign start_edge = (state == IDLE) && start;
  assign fail       = (state == CHECK) && (ok_clean != {NCHK{1'b1}});
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = !empty && rd_ready;
  assign push       = fail && (!full || pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      warm_cnt   <= '0;
      tstamp     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fail_any   <= 1'b0;
      fail_count <= '0;
      first_time <= '0;
      overflow   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);

      if (start_edge) begin
        tstamp     <= '0;
        warm_cnt   <= WW'(WARMUP - 1);
        fail_any   <= 1'b0;
        fail_count <= '0;
        first_time <= '0;
        overflow   <= 1'b0;
      end else begin
        if (state != IDLE && tstamp != {TSW{1'b1}}) tstamp <= tstamp + TSW'(1);
        if (state == WARM && warm_cnt != '0) warm_cnt <= warm_cnt - WW'(1);
        if (fail) begin
          if (fail_count != {TSW{1'b1}}) fail_count <= fail_count + TSW'(1);
          if (!fail_any) begin
            fail_any   <= 1'b1;
            first_time <= tstamp;
          end
          if (full && !pop) overflow <= 1'b1;
        end
      end
    end
  end

  // Storage needs no reset: head outputs are gated by empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_time[wr_ptr[AW-1:0]] <= tstamp;
      mem_vec[wr_ptr[AW-1:0]]  <= ok_clean;
    end
  end

  assign rd_valid = !empty;
  assign rd_time  = empty ? '0 : mem_time[rd_ptr[AW-1:0]];
  assign rd_okvec = empty ? '0 : mem_vec[rd_ptr[AW-1:0]];
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_flop_mismatch_log.sv
// Directed bench for flop_mismatch_log: a step table for run control and summaries,
// plus hand sequences for timestamps, FIFO full/overflow, drain order and reset.
module tb_flop_mismatch_log;

  localparam int NCHK = 22;
  localparam logic [NCHK-1:0] ONES = {NCHK{1'b1}};

  logic            clk = 1'b0;
  logic            rst_n, start, stop, rd_ready;
  logic [NCHK-1:0] ok;
  logic            rd_valid, fail_any, overflow, busy;
  logic [31:0]     rd_time, fail_count, first_time;
  logic [NCHK-1:0] rd_okvec;
  logic [NCHK-1:0] ok_tmp;

  int checks = 0;
  int failures = 0;

  flop_mismatch_log #(.NCHK(NCHK), .DEPTH(8), .TSW(32), .WARMUP(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .ok(ok),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_time(rd_time), .rd_okvec(rd_okvec),
    .fail_any(fail_any), .fail_count(fail_count), .first_time(first_time),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            start;
    logic            stop;
    logic            rd_ready;
    logic [NCHK-1:0] ok;
    int              n;
    logic            busy;
    logic            fail_any;
    logic [31:0]     fail_count;
    logic            rd_valid;
    logic            overflow;
  } step_t;

  step_t steps [11];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_to_check();
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (10) cyc();
  endtask

  initial begin
    //              start stop rdy ok                n   busy fany cnt rdv ovf
    steps[0]  = '{1'b1, 1'b0, 1'b0, ONES,              41, 1'b1, 1'b0, 0, 1'b0, 1'b0};
    steps[1]  = '{1'b0, 1'b1, 1'b0, ONES,              1,  1'b0, 1'b0, 0, 1'b0, 1'b0};
    steps[2]  = '{1'b0, 1'b1, 1'b0, ONES,              1,  1'b0, 1'b0, 0, 1'b0, 1'b0};
    steps[3]  = '{1'b1, 1'b0, 1'b0, ONES & ~22'h8,     11, 1'b1, 1'b0, 0, 1'b0, 1'b0};
    steps[4]  = '{1'b0, 1'b0, 1'b0, ONES,              5,  1'b1, 1'b0, 0, 1'b0, 1'b0};
    steps[5]  = '{1'b0, 1'b1, 1'b0, ONES,              1,  1'b0, 1'b0, 0, 1'b0, 1'b0};
    steps[6]  = '{1'b1, 1'b1, 1'b0, ONES,              1,  1'b1, 1'b0, 0, 1'b0, 1'b0};
    steps[7]  = '{1'b1, 1'b0, 1'b0, ONES,              12, 1'b1, 1'b0, 0, 1'b0, 1'b0};
    steps[8]  = '{1'b0, 1'b0, 1'b1, '0,                3,  1'b1, 1'b1, 3, 1'b1, 1'b0};
    steps[9]  = '{1'b0, 1'b1, 1'b1, '0,                1,  1'b0, 1'b1, 4, 1'b1, 1'b0};
    steps[10] = '{1'b0, 1'b1, 1'b1, '0,                2,  1'b0, 1'b1, 4, 1'b0, 1'b0};

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; rd_ready = 1'b0; ok = ONES;
    repeat (3) cyc();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_time", rd_time, 0);
    chk("rst_rd_okvec", 32'(rd_okvec), 0);
    chk("rst_fail_any", 32'(fail_any), 0);
    chk("rst_fail_count", fail_count, 0);
    chk("rst_first_time", first_time, 0);
    chk("rst_overflow", 32'(overflow), 0);
    rst_n = 1'b1;
    cyc();

    foreach (steps[i]) begin
      start = steps[i].start; stop = steps[i].stop;
      rd_ready = steps[i].rd_ready; ok = steps[i].ok;
      cyc();
      start = 1'b0; stop = 1'b0;
      repeat (steps[i].n - 1) cyc();
      chk($sformatf("step%0d_busy", i), 32'(busy), 32'(steps[i].busy));
      chk($sformatf("step%0d_fail_any", i), 32'(fail_any), 32'(steps[i].fail_any));
      chk($sformatf("step%0d_fail_count", i), fail_count, steps[i].fail_count);
      chk($sformatf("step%0d_rd_valid", i), 32'(rd_valid), 32'(steps[i].rd_valid));
      chk($sformatf("step%0d_overflow", i), 32'(overflow), 32'(steps[i].overflow));
    end
    ok = ONES; rd_ready = 1'b0;

    // Fails at tstamp 12 (bit0 unknown) and 15 (bit21 low)
    run_to_check();
    repeat (2) cyc();
    ok_tmp = ONES; ok_tmp[0] = 1'bx; ok = ok_tmp;
    cyc();
    ok = ONES;
    repeat (2) cyc();
    ok_tmp = ONES; ok_tmp[21] = 1'b0; ok = ok_tmp;
    cyc();
    ok = ONES;
    cyc();
    chk("t3_rd_valid", 32'(rd_valid), 1);
    chk("t3_time0", rd_time, 12);
    chk("t3_okvec0", 32'(rd_okvec), 32'h3FFFFE);
    chk("t3_first_time", first_time, 12);
    chk("t3_fail_count", fail_count, 2);
    cyc();
    chk("t3_hold_time", rd_time, 12);
    rd_ready = 1'b1; cyc(); rd_ready = 1'b0;
    chk("t3_time1", rd_time, 15);
    chk("t3_okvec1", 32'(rd_okvec), 32'h1FFFFF);
    rd_ready = 1'b1; cyc(); rd_ready = 1'b0;
    chk("t3_empty", 32'(rd_valid), 0);
    stop = 1'b1; cyc(); stop = 1'b0;

    // Ten fails into an 8-deep FIFO with no reader
    run_to_check();
    ok = '0;
    repeat (10) cyc();
    ok = ONES;
    cyc();
    chk("t4_overflow", 32'(overflow), 1);
    chk("t4_fail_count", fail_count, 10);
    chk("t4_first_time", first_time, 10);
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t4_valid%0d", i), 32'(rd_valid), 1);
      chk($sformatf("t4_time%0d", i), rd_time, 32'(10 + i));
      cyc();
    end
    chk("t4_drained", 32'(rd_valid), 0);
    rd_ready = 1'b0;
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("t4_idle", 32'(busy), 0);

    // Full FIFO, pop and push in the same cycle
    run_to_check();
    ok = '0;
    repeat (8) cyc();
    chk("t5_full_no_ovf", 32'(overflow), 0);
    rd_ready = 1'b1;
    cyc();
    rd_ready = 1'b0; ok = ONES;
    cyc();
    chk("t5_overflow", 32'(overflow), 0);
    chk("t5_fail_count", fail_count, 9);
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t5_valid%0d", i), 32'(rd_valid), 1);
      chk($sformatf("t5_time%0d", i), rd_time, 32'(11 + i));
      cyc();
    end
    chk("t5_drained", 32'(rd_valid), 0);
    rd_ready = 1'b0;
    stop = 1'b1; cyc(); stop = 1'b0;

    // Reset mid-CHECK with three entries queued
    run_to_check();
    ok = '0;
    repeat (3) cyc();
    ok = ONES;
    chk("t6_queued", 32'(rd_valid), 1);
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    chk("t6_rd_valid", 32'(rd_valid), 0);
    chk("t6_fail_any", 32'(fail_any), 0);
    chk("t6_fail_count", fail_count, 0);
    chk("t6_first_time", first_time, 0);
    chk("t6_overflow", 32'(overflow), 0);
    chk("t6_busy", 32'(busy), 0);
    start = 1'b1; cyc(); start = 1'b0;
    chk("t6_restart", 32'(busy), 1);
    stop = 1'b1; cyc(); stop = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
